// File: rtl/cgupll_cfgseq.sv
`default_nettype none
// ============================================================================
// Module   : cgupll_cfgseq
// Purpose  : Initiator side of the CGU PLL setcfg/lock handshake. Captures a
//            requested PLL configuration into a shadow bus, issues a single
//            setcfg strobe, waits out the wrapper apply window, then waits for
//            a debounced lock or a timeout and reports the outcome.
// Options  : CGUPLL_CFGSEQ_RETRY_EN - first timeout of a sequence reissues
//            setcfg with a reloaded timeout; only a second timeout fails.
// Revision : 1.0 - initial release
// ============================================================================
module cgupll_cfgseq #(
    parameter int PREDIV_W   = 5,
    parameter int FBDIV_W    = 12,
    parameter int FRAC_W     = 24,
    parameter int POSTDIV_W0 = 3,
    parameter int POSTDIV_W1 = 3,
    parameter int TMO_W      = 16,
    parameter int SETTLE_CYC = 32,
    parameter int GUARD_CYC  = 12
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  cfg_req,
    input  logic                  cfg_off,
    input  logic [PREDIV_W-1:0]   cfg_m,
    input  logic [FBDIV_W-1:0]    cfg_n,
    input  logic [FRAC_W-1:0]     cfg_f,
    input  logic                  cfg_fen,
    input  logic [POSTDIV_W0-1:0] cfg_q00,
    input  logic [POSTDIV_W1-1:0] cfg_q10,
    input  logic [POSTDIV_W0-1:0] cfg_q01,
    input  logic [POSTDIV_W1-1:0] cfg_q11,
    input  logic [TMO_W-1:0]      cfg_tmo,
    input  logic                  err_clr,
    input  logic                  lock,
    output logic                  pllen,
    output logic                  setcfg,
    output logic [PREDIV_W-1:0]   pll_m,
    output logic [FBDIV_W-1:0]    pll_n,
    output logic [FRAC_W-1:0]     pll_f,
    output logic                  pll_fen,
    output logic [POSTDIV_W0-1:0] pll_q00,
    output logic [POSTDIV_W1-1:0] pll_q10,
    output logic [POSTDIV_W0-1:0] pll_q01,
    output logic [POSTDIV_W1-1:0] pll_q11,
    output logic                  busy,
    output logic                  done,
    output logic                  done_ok,
    output logic                  err_tmo
);

    // Guard counter must be able to hold GUARD_CYC itself; settle only needs SETTLE_CYC-1.
    localparam int c_GUARD_W  = (GUARD_CYC  > 0) ? $clog2(GUARD_CYC + 1) : 1;
    localparam int c_SETTLE_W = (SETTLE_CYC > 1) ? $clog2(SETTLE_CYC)    : 1;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_PULSE  = 3'd1,
        ST_GUARD  = 3'd2,
        ST_WAITLK = 3'd3,
        ST_DONE   = 3'd4
    } state_t;

    state_t                  r_state;
    state_t                  w_state_nxt;

    logic [1:0]              r_lock_sync;
    logic                    w_lock_s;

    logic [c_GUARD_W-1:0]    r_guard_cnt;
    logic [c_SETTLE_W-1:0]   r_settle_cnt;
    logic [TMO_W-1:0]        r_tmo_cnt;
    logic                    r_tmo_en;

    logic [PREDIV_W-1:0]     r_m;
    logic [FBDIV_W-1:0]      r_n;
    logic [FRAC_W-1:0]       r_f;
    logic                    r_fen;
    logic [POSTDIV_W0-1:0]   r_q00;
    logic [POSTDIV_W1-1:0]   r_q10;
    logic [POSTDIV_W0-1:0]   r_q01;
    logic [POSTDIV_W1-1:0]   r_q11;

    logic                    r_pllen;
    logic                    r_done_ok;
    logic                    r_err_tmo;

    logic                    w_capture;
    logic                    w_guard_end;
    logic                    w_settle_hit;
    logic                    w_tmo_hit;
    logic                    w_tmo_tick;
    logic                    w_fin_ok;
    logic                    w_fin_fail;
    logic                    w_setcfg;
    logic                    w_busy;
    logic                    w_done;

`ifdef CGUPLL_CFGSEQ_RETRY_EN
    logic [TMO_W-1:0]        r_tmo_rl;
    logic                    r_retried;
    logic                    w_retry;
`endif

    assign w_lock_s     = r_lock_sync[1];
    assign w_capture    = (r_state == ST_IDLE) && cfg_req;
    assign w_guard_end  = (r_guard_cnt == c_GUARD_W'(GUARD_CYC));
    assign w_settle_hit = w_lock_s && (r_settle_cnt == c_SETTLE_W'(SETTLE_CYC - 1));
    // The decrement happening this cycle lands on zero (or it is already there).
    assign w_tmo_hit    = r_tmo_en && (r_tmo_cnt <= TMO_W'(1));
    assign w_tmo_tick   = r_tmo_en && ((r_state == ST_GUARD) || (r_state == ST_WAITLK));
    // Timeout wins over a settle completion in the same cycle.
    assign w_fin_ok     = (r_state == ST_WAITLK) && !w_tmo_hit && w_settle_hit;

`ifdef CGUPLL_CFGSEQ_RETRY_EN
    assign w_retry      = (r_state == ST_WAITLK) && w_tmo_hit && !r_retried;
    assign w_fin_fail   = (r_state == ST_WAITLK) && w_tmo_hit && r_retried;
`else
    assign w_fin_fail   = (r_state == ST_WAITLK) && w_tmo_hit;
`endif

    // Two-flop synchroniser for the asynchronous PLL lock.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_lock_sync <= 2'b00;
        end else begin
            r_lock_sync <= {r_lock_sync[0], lock};
        end
    end

    // Sequencer state register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state and strobe decode.
    always_comb begin
        w_state_nxt = r_state;
        w_setcfg    = 1'b0;
        w_busy      = 1'b1;
        w_done      = 1'b0;
        case (r_state)
            ST_IDLE: begin
                w_busy = 1'b0;
                if (cfg_req) begin
                    w_state_nxt = ST_PULSE;
                end
            end
            ST_PULSE: begin
                w_setcfg    = 1'b1;
                w_state_nxt = ST_GUARD;
            end
            ST_GUARD: begin
                if (w_guard_end) begin
                    w_state_nxt = ST_WAITLK;
                end
            end
            ST_WAITLK: begin
                if (w_tmo_hit) begin
`ifdef CGUPLL_CFGSEQ_RETRY_EN
                    w_state_nxt = r_retried ? ST_DONE : ST_PULSE;
`else
                    w_state_nxt = ST_DONE;
`endif
                end else if (w_settle_hit) begin
                    w_state_nxt = ST_DONE;
                end
            end
            ST_DONE: begin
                w_done      = 1'b1;
                w_state_nxt = ST_IDLE;
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // Guard window counter: cleared while pulsing, saturates at GUARD_CYC.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_guard_cnt <= '0;
        end else if (r_state == ST_PULSE) begin
            r_guard_cnt <= '0;
        end else if ((r_state == ST_GUARD) && !w_guard_end) begin
            r_guard_cnt <= r_guard_cnt + c_GUARD_W'(1);
        end
    end

    // Consecutive synced-lock counter; any low lock_s restarts the settle window.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_settle_cnt <= '0;
        end else if ((r_state != ST_WAITLK) || !w_lock_s) begin
            r_settle_cnt <= '0;
        end else if (r_settle_cnt != c_SETTLE_W'(SETTLE_CYC - 1)) begin
            r_settle_cnt <= r_settle_cnt + c_SETTLE_W'(1);
        end
    end

    // Timeout down-counter; armed at capture, stops at zero.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_tmo_cnt <= '0;
            r_tmo_en  <= 1'b0;
        end else if (w_capture) begin
            r_tmo_cnt <= cfg_tmo;
            r_tmo_en  <= (cfg_tmo != '0);
`ifdef CGUPLL_CFGSEQ_RETRY_EN
        end else if (w_retry) begin
            r_tmo_cnt <= r_tmo_rl;
`endif
        end else if (w_tmo_tick && (r_tmo_cnt != '0)) begin
            r_tmo_cnt <= r_tmo_cnt - TMO_W'(1);
        end
    end

`ifdef CGUPLL_CFGSEQ_RETRY_EN
    // Retry bookkeeping: reload value and one-shot retry flag per sequence.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_tmo_rl  <= '0;
            r_retried <= 1'b0;
        end else if (w_capture) begin
            r_tmo_rl  <= cfg_tmo;
            r_retried <= 1'b0;
        end else if (w_retry) begin
            r_retried <= 1'b1;
        end
    end
`endif

    // Shadow configuration; only updated on the IDLE->PULSE capture.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_m   <= '0;
            r_n   <= '0;
            r_f   <= '0;
            r_fen <= 1'b0;
            r_q00 <= '0;
            r_q10 <= '0;
            r_q01 <= '0;
            r_q11 <= '0;
        end else if (w_capture) begin
            r_m   <= cfg_m;
            r_n   <= cfg_n;
            r_f   <= cfg_f;
            r_fen <= cfg_fen;
            r_q00 <= cfg_q00;
            r_q10 <= cfg_q10;
            r_q01 <= cfg_q01;
            r_q11 <= cfg_q11;
        end
    end

    // PLL enable: a request always enables, cfg_off only disables from IDLE.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_pllen <= 1'b0;
        end else if (w_capture || (r_state == ST_PULSE)) begin
            r_pllen <= 1'b1;
        end else if ((r_state == ST_IDLE) && cfg_off) begin
            r_pllen <= 1'b0;
        end
    end

    // Result flag, registered on the way into DONE so it lines up with done.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_done_ok <= 1'b0;
        end else begin
            r_done_ok <= w_fin_ok;
        end
    end

    // Sticky timeout error; a new failure beats a simultaneous clear.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_err_tmo <= 1'b0;
        end else if (w_fin_fail) begin
            r_err_tmo <= 1'b1;
        end else if (err_clr) begin
            r_err_tmo <= 1'b0;
        end
    end

    assign pllen   = r_pllen;
    assign setcfg  = w_setcfg;
    assign busy    = w_busy;
    assign done    = w_done;
    assign done_ok = r_done_ok;
    assign err_tmo = r_err_tmo;
    assign pll_m   = r_m;
    assign pll_n   = r_n;
    assign pll_f   = r_f;
    assign pll_fen = r_fen;
    assign pll_q00 = r_q00;
    assign pll_q10 = r_q10;
    assign pll_q01 = r_q01;
    assign pll_q11 = r_q11;

endmodule
`default_nettype wire

// File: tb/tb_cgupll_cfgseq.sv
`default_nettype none
// ============================================================================
// Module   : tb_cgupll_cfgseq
// Purpose  : Directed self-checking bench for cgupll_cfgseq. Cycle numbers are
//            counted in clock edges; "P" is the cycle in which setcfg is high.
// Revision : 1.0 - initial release
// ============================================================================
module tb_cgupll_cfgseq;

    logic        clk;
    logic        reset;
    logic        cfg_req;
    logic        cfg_off;
    logic [4:0]  cfg_m;
    logic [11:0] cfg_n;
    logic [23:0] cfg_f;
    logic        cfg_fen;
    logic [2:0]  cfg_q00, cfg_q10, cfg_q01, cfg_q11;
    logic [15:0] cfg_tmo;
    logic        err_clr;
    logic        lock;
    logic        pllen, setcfg, busy, done, done_ok, err_tmo;
    logic [4:0]  pll_m;
    logic [11:0] pll_n;
    logic [23:0] pll_f;
    logic        pll_fen;
    logic [2:0]  pll_q00, pll_q10, pll_q01, pll_q11;

    int n_total = 0;
    int n_bad   = 0;
    int cyc     = 0;

    cgupll_cfgseq dut (
        .clk     (clk),
        .reset   (reset),
        .cfg_req (cfg_req),
        .cfg_off (cfg_off),
        .cfg_m   (cfg_m),
        .cfg_n   (cfg_n),
        .cfg_f   (cfg_f),
        .cfg_fen (cfg_fen),
        .cfg_q00 (cfg_q00),
        .cfg_q10 (cfg_q10),
        .cfg_q01 (cfg_q01),
        .cfg_q11 (cfg_q11),
        .cfg_tmo (cfg_tmo),
        .err_clr (err_clr),
        .lock    (lock),
        .pllen   (pllen),
        .setcfg  (setcfg),
        .pll_m   (pll_m),
        .pll_n   (pll_n),
        .pll_f   (pll_f),
        .pll_fen (pll_fen),
        .pll_q00 (pll_q00),
        .pll_q10 (pll_q10),
        .pll_q01 (pll_q01),
        .pll_q11 (pll_q11),
        .busy    (busy),
        .done    (done),
        .done_ok (done_ok),
        .err_tmo (err_tmo)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%0d expected=%0d", tag, got, exp);
        end
    endtask

    // Advance one clock; inputs are driven and outputs sampled 1ns after the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Issue a one-cycle request; p returns the cycle in which setcfg should be high.
    task automatic start_seq(input string pfx, input logic [11:0] n, input logic [4:0] m,
                             input logic [15:0] tmo, output int p);
        cfg_n   = n;
        cfg_m   = m;
        cfg_tmo = tmo;
        cfg_req = 1'b1;
        tick();
        cfg_req = 1'b0;
        p = cyc;
        chk({pfx, "_setcfg"}, setcfg, 1);
        chk({pfx, "_pll_n"},  pll_n,  n);
    endtask

    // Run up to budget cycles; record first done, its flags, and setcfg/done counts.
    task automatic wait_done(input int budget, input bit stop_on_done, output int at,
                             output int nset, output int ndone,
                             output logic ok, output logic err);
        at = -1; nset = 0; ndone = 0; ok = 1'bx; err = 1'bx;
        for (int i = 0; i < budget; i++) begin
            tick();
            if (setcfg) nset++;
            if (done) begin
                ndone++;
                if (at < 0) begin
                    at  = cyc;
                    ok  = done_ok;
                    err = err_tmo;
                end
                if (stop_on_done) break;
            end
        end
    endtask

    initial begin
        int   p, at, nset, ndone;
        logic ok, err;

        reset = 1'b1; cfg_req = 1'b0; cfg_off = 1'b0; err_clr = 1'b0; lock = 1'b1;
        cfg_m = '0; cfg_n = '0; cfg_tmo = '0; cfg_f = 24'h12_3456; cfg_fen = 1'b1;
        cfg_q00 = 3'd1; cfg_q10 = 3'd2; cfg_q01 = 3'd3; cfg_q11 = 3'd4;
        tick(); tick();

        // Reset state.
        chk("rst_pllen",   pllen,   0);
        chk("rst_setcfg",  setcfg,  0);
        chk("rst_busy",    busy,    0);
        chk("rst_done",    done,    0);
        chk("rst_done_ok", done_ok, 0);
        chk("rst_err_tmo", err_tmo, 0);
        chk("rst_pll_n",   pll_n,   0);
        reset = 1'b0;
        tick(); tick(); tick();

        // Steady lock: done at P + 1 + 12 + 32 + 1.
        start_seq("t2a", 12'd1432, 5'd31, 16'd0, p);
        chk("t2a_pll_m",  pll_m,  31);
        chk("t2a_pll_f",  pll_f,  24'h12_3456);
        chk("t2a_pllen",  pllen,  1);
        chk("t2a_busy",   busy,   1);
        wait_done(100, 1'b1, at, nset, ndone, ok, err);
        chk("t2a_done_at", at - p, 46);
        chk("t2a_nset",    nset,   0);
        chk("t2a_done_ok", ok,     1);
        chk("t2a_err",     err,    0);
        tick();
        chk("t2a_done_pulse", done,    0);
        chk("t2a_ok_pulse",   done_ok, 0);
        chk("t2a_idle",       busy,    0);

        // Lock rises at P+20: lock_s high from P+22, 32 cycles later -> done at P+54.
        lock = 1'b0;
        tick(); tick(); tick();
        start_seq("t2b", 12'd1432, 5'd31, 16'd0, p);
        for (int i = 0; i < 20; i++) tick();
        lock = 1'b1;
        wait_done(100, 1'b1, at, nset, ndone, ok, err);
        chk("t2b_done_at", at - p, 54);
        chk("t2b_done_ok", ok,     1);
        tick();

        // One-cycle lock glitch at P+20: lock_s low in P+22, high P+23..P+54, done P+55.
        start_seq("t3", 12'd1432, 5'd31, 16'd0, p);
        for (int i = 0; i < 20; i++) tick();
        lock = 1'b0;
        tick();
        lock = 1'b1;
        wait_done(100, 1'b1, at, nset, ndone, ok, err);
        chk("t3_done_at", at - p, 55);
        chk("t3_done_ok", ok,     1);
        tick();

        // cfg_off in IDLE drops pllen; cfg_off with cfg_req starts a sequence.
        chk("t6_pllen_before", pllen, 1);
        cfg_off = 1'b1;
        tick();
        cfg_off = 1'b0;
        chk("t6_pllen_off", pllen, 0);
        chk("t6_busy_off",  busy,  0);
        cfg_off = 1'b1;
        start_seq("t6", 12'd1000, 5'd7, 16'd0, p);
        cfg_off = 1'b0;
        chk("t6_pllen_on", pllen, 1);
        chk("t6_busy_on",  busy,  1);
        wait_done(100, 1'b1, at, nset, ndone, ok, err);
        chk("t6_done_at", at - p, 46);
        tick();

        // Request while busy is ignored.
        start_seq("t5", 12'd1432, 5'd31, 16'd0, p);
        tick(); tick(); tick();
        cfg_n   = 12'd1482;
        cfg_req = 1'b1;
        tick();
        cfg_req = 1'b0;
        wait_done(80, 1'b0, at, nset, ndone, ok, err);
        chk("t5_done_at", at - p, 46);
        chk("t5_ndone",   ndone,  1);
        chk("t5_nset",    nset,   0);
        chk("t5_pll_n",   pll_n,  1432);

        // Timeout of 100 with no lock: cycles P+1..P+100 counted, done at P+101.
        lock = 1'b0;
        tick(); tick(); tick();
        start_seq("t4", 12'd1432, 5'd31, 16'd100, p);
        wait_done(300, 1'b1, at, nset, ndone, ok, err);
`ifdef CGUPLL_CFGSEQ_RETRY_EN
        chk("t4_done_at", at - p, 202);
        chk("t4_nset",    nset,   1);
`else
        chk("t4_done_at", at - p, 101);
        chk("t4_nset",    nset,   0);
`endif
        chk("t4_done_ok", ok,  0);
        chk("t4_err_tmo", err, 1);
        tick();
        chk("t4_err_sticky", err_tmo, 1);
        chk("t4_idle",       busy,    0);
        err_clr = 1'b1;
        tick();
        err_clr = 1'b0;
        chk("t4_err_clr", err_tmo, 0);

        // Asynchronous reset in the middle of WAITLK.
        start_seq("t1", 12'd1432, 5'd31, 16'd0, p);
        for (int i = 0; i < 20; i++) tick();
        chk("t1_busy_pre", busy, 1);
        reset = 1'b1;
        #1;
        chk("t1_busy_async",  busy,  0);
        chk("t1_pllen_async", pllen, 0);
        tick();
        chk("t1_pllen",  pllen,  0);
        chk("t1_setcfg", setcfg, 0);
        chk("t1_busy",   busy,   0);
        chk("t1_done",   done,   0);
        chk("t1_pll_n",  pll_n,  0);
        chk("t1_pll_m",  pll_m,  0);
        reset = 1'b0;
        lock  = 1'b1;
        wait_done(60, 1'b0, at, nset, ndone, ok, err);
        chk("t1_no_done", ndone, 0);
        chk("t1_no_set",  nset,  0);
        chk("t1_idle",    busy,  0);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire
